// File: rtl/ebu_arb_pkg.sv
// Shared types for the EBU AHB arbiter: FSM state encoding and HBURST-to-threshold mapping.
package ebu_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int unsigned BeatCntW = 4;

    // Last beat index of a burst: SINGLE/INCR -> 0, x4 -> 3, x8 -> 7, x16 -> 15.
    function automatic logic [BeatCntW-1:0] burst_threshold(input logic [2:0] hburst);
        logic [BeatCntW-1:0] thr;
        unique case (hburst[2:1])
            2'b00:   thr = 4'd0;
            2'b01:   thr = 4'd3;
            2'b10:   thr = 4'd7;
            default: thr = 4'd15;
        endcase
        return thr;
    endfunction

endpackage

// File: rtl/ebu_beatcnt.sv
// Beat counter for the current burst owner: clears on acceptance, saturates at the threshold.
module ebu_beatcnt
    import ebu_arb_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic [BeatCntW-1:0] thresh_i,
    output logic [BeatCntW-1:0] count_o,
    output logic                terminal_o
);

    logic [BeatCntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != thresh_i)) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign terminal_o = (count_q == thresh_i);

endmodule

// File: rtl/ebu_rr_arb.sv
// AHB burst arbiter: holds the grant for a whole burst and re-arbitrates on its final beat.
// Round-robin selection is enabled by defining EBU_ARB_ROUNDROBIN_EN; otherwise fixed priority.
module ebu_rr_arb
    import ebu_arb_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IDXW = $clog2(NREQ)
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [NREQ-1:0]   Req,
    input  logic [NREQ*3-1:0] ReqBurst,
    input  logic              HREADY,
    output logic [NREQ-1:0]   Grant,
    output logic [IDXW-1:0]   GrantIdx,
    output logic              Busy,
    output logic              FinalBeat
);

    arb_state_e          state_q, state_d;
    logic [IDXW-1:0]     owner_q, owner_d;
    logic [BeatCntW-1:0] thresh_q, thresh_d;
    logic [BeatCntW-1:0] beat_cnt;
    logic                beat_term;

    logic                win_valid;
    logic [IDXW-1:0]     win_idx;
    logic [2:0]          win_burst;
    logic                final_beat;
    logic                arb_phase;
    logic                accept;
    logic                beat_en;

`ifdef EBU_ARB_ROUNDROBIN_EN
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0] req_hi;

    // Prefer the lowest request at or above the pointer, else wrap to the lowest overall.
    always_comb begin
        req_hi    = Req & ~((NREQ'(1) << ptr_q) - NREQ'(1));
        win_valid = |Req;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (Req[k]) win_idx = IDXW'(k);
        end
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_hi[k]) win_idx = IDXW'(k);
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (win_idx == IDXW'(NREQ - 1)) ? '0 : win_idx + IDXW'(1);
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        win_valid = |Req;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (Req[k]) win_idx = IDXW'(k);
        end
    end
`endif

    always_comb begin
        win_burst = 3'b000;
        for (int k = 0; k < NREQ; k++) begin
            if (win_idx == IDXW'(k)) win_burst = ReqBurst[3*k +: 3];
        end
    end

    assign final_beat = (state_q == BURST) && beat_term;
    assign arb_phase  = (state_q == IDLE) || final_beat;
    assign accept     = arb_phase && HREADY && win_valid;
    assign beat_en    = (state_q == BURST) && !beat_term && HREADY;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        thresh_d = thresh_q;
        if (accept) begin
            state_d  = BURST;
            owner_d  = win_idx;
            thresh_d = burst_threshold(win_burst);
        end else if (final_beat && HREADY) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            thresh_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            thresh_q <= thresh_d;
        end
    end

    ebu_beatcnt u_beatcnt (
        .clk_i      (HCLK),
        .rst_i      (HRESET),
        .clr_i      (accept),
        .en_i       (beat_en),
        .thresh_i   (thresh_q),
        .count_o    (beat_cnt),
        .terminal_o (beat_term)
    );

    // Owner keeps the address phase until its final beat, where the next winner is shown.
    always_comb begin
        Grant    = '0;
        GrantIdx = '0;
        if (arb_phase) begin
            if (win_valid) begin
                Grant    = NREQ'(1) << win_idx;
                GrantIdx = win_idx;
            end
        end else begin
            Grant    = NREQ'(1) << owner_q;
            GrantIdx = owner_q;
        end
    end

    assign Busy      = (state_q == BURST);
    assign FinalBeat = final_beat;

endmodule

// File: tb/tb_ebu_rr_arb.sv
// Directed self-checking bench for ebu_rr_arb (NREQ=3); expectations follow EBU_ARB_ROUNDROBIN_EN.
module tb_ebu_rr_arb;

`ifdef EBU_ARB_ROUNDROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       HCLK;
    logic       HRESET;
    logic [2:0] Req;
    logic [8:0] ReqBurst;
    logic       HREADY;
    logic [2:0] Grant;
    logic [1:0] GrantIdx;
    logic       Busy;
    logic       FinalBeat;

    int vecs;
    int errs;

    ebu_rr_arb #(
        .NREQ (3),
        .IDXW (2)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .Req       (Req),
        .ReqBurst  (ReqBurst),
        .HREADY    (HREADY),
        .Grant     (Grant),
        .GrantIdx  (GrantIdx),
        .Busy      (Busy),
        .FinalBeat (FinalBeat)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        vecs     = 0;
        errs     = 0;
        HRESET   = 1'b1;
        Req      = 3'b000;
        ReqBurst = 9'b0;
        HREADY   = 1'b0;
        #2;
        chk("rst_grant", Grant, 3'b000);
        chk("rst_idx", GrantIdx, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_final", FinalBeat, 0);
        Req = 3'b110;
        #1;
        chk("rst_arb_grant", Grant, 3'b010);
        chk("rst_arb_idx", GrantIdx, 1);

        tick();
        HRESET = 1'b0;
        // No acceptance without HREADY
        Req = 3'b001;
        #1;
        chk("idle_grant", Grant, 3'b001);
        tick();
        chk("idle_hold_busy", Busy, 0);

        // Single-beat transfers back to back
        Req    = 3'b011;
        HREADY = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("single_grant", Grant, (RR && (i % 2 == 1)) ? 3'b010 : 3'b001);
            chk("single_busy", Busy, (i > 0));
            chk("single_final", FinalBeat, (i > 0));
            tick();
        end
        Req = 3'b000;
        #1;
        chk("final_noreq_grant", Grant, 3'b000);
        chk("final_noreq_idx", GrantIdx, 0);
        chk("final_noreq_final", FinalBeat, 1);
        tick();
        chk("to_idle_busy", Busy, 0);
        chk("to_idle_final", FinalBeat, 0);
        chk("to_idle_grant", Grant, 3'b000);

        // INCR4 owner 0, requester 1 waits for the handover
        Req      = 3'b001;
        ReqBurst = 9'b000_000_011;
        #1;
        chk("incr4_first_grant", Grant, 3'b001);
        tick();
        Req = 3'b010;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("incr4_hold_grant", Grant, 3'b001);
            chk("incr4_hold_final", FinalBeat, 0);
            tick();
        end
        chk("handover_final", FinalBeat, 1);
        chk("handover_grant", Grant, 3'b010);
        chk("handover_idx", GrantIdx, 1);
        tick();
        chk("new_owner_idx", GrantIdx, 1);
        chk("new_owner_busy", Busy, 1);
        Req = 3'b000;
        #1;
        tick();
        chk("handover_done_busy", Busy, 0);

        // INCR8 with two wait states at beat 3
        Req      = 3'b100;
        ReqBurst = 9'b101_000_000;
        #1;
        chk("incr8_grant", Grant, 3'b100);
        chk("incr8_idx", GrantIdx, 2);
        tick();
        Req = 3'b000;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("incr8_early_final", FinalBeat, 0);
            chk("incr8_early_grant", Grant, 3'b100);
            tick();
        end
        HREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("wait_grant", Grant, 3'b100);
            chk("wait_final", FinalBeat, 0);
            chk("wait_busy", Busy, 1);
        end
        HREADY = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("incr8_late_final", FinalBeat, 0);
            tick();
        end
        chk("incr8_last_final", FinalBeat, 1);
        chk("incr8_last_grant", Grant, 3'b000);
        HREADY = 1'b0;
        tick();
        chk("final_wait_final", FinalBeat, 1);
        chk("final_wait_busy", Busy, 1);
        HREADY = 1'b1;
        #1;
        tick();
        chk("incr8_done_busy", Busy, 0);

        // Reset mid-INCR16
        Req      = 3'b010;
        ReqBurst = 9'b000_111_000;
        #1;
        chk("incr16_grant", Grant, 3'b010);
        tick();
        Req = 3'b000;
        #1;
        for (int i = 0; i < 5; i++) tick();
        chk("incr16_mid_busy", Busy, 1);
        chk("incr16_mid_grant", Grant, 3'b010);
        chk("incr16_mid_final", FinalBeat, 0);
        HRESET = 1'b1;
        #1;
        chk("midrst_busy", Busy, 0);
        chk("midrst_final", FinalBeat, 0);
        Req = 3'b110;
        #1;
        chk("midrst_grant", Grant, 3'b010);
        tick();
        HRESET = 1'b0;
        #1;
        chk("post_rst_busy", Busy, 0);
        chk("post_rst_grant", Grant, 3'b010);
        chk("post_rst_idx", GrantIdx, 1);
        Req = 3'b000;
        #1;

        // Owner drops Req during INCR4; burst still runs 4 beats
        Req      = 3'b001;
        ReqBurst = 9'b000_000_011;
        #1;
        tick();
        Req = 3'b000;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("drop_grant", Grant, 3'b001);
            chk("drop_final", FinalBeat, 0);
            tick();
        end
        chk("drop_last_final", FinalBeat, 1);
        chk("drop_last_grant", Grant, 3'b000);
        chk("drop_last_idx", GrantIdx, 0);
        tick();
        chk("drop_done_busy", Busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ebu_rr_arb.md
EBU_RR_ARB -- requirements
Module: ebu_rr_arb

Interface
REQ-001 Parameter NREQ, default 3, number of AHB requesters (2..8).
REQ-002 Parameter IDXW, default $clog2(NREQ), width of the grant index.
REQ-003 Port HCLK  input  1  bus clock; all state updates on the rising edge.
REQ-004 Port HRESET  input  1  reset, asynchronous, active-high.
REQ-005 Port Req  input  NREQ  per-requester transfer request; bit i = requester i.
REQ-006 Port ReqBurst  input  NREQ*3  per-requester HBURST; slice [3i+2:3i] belongs to requester i.
REQ-007 Port HREADY  input  1  AHB beat-complete strobe.
REQ-008 Port Grant  output  NREQ  one-hot (or zero) address-phase grant.
REQ-009 Port GrantIdx  output  IDXW  binary index of the Grant bit; 0 when Grant is zero.
REQ-010 Port Busy  output  1  high while a data phase is owned (state BURST).
REQ-011 Port FinalBeat  output  1  high while the owner's last data phase is in progress.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and BURST.
REQ-013 Threshold SHALL be 0 for HBURST[2:1]=00 and (2<<HBURST[2:1])-1 otherwise (3, 7, 15); latched from the winner's ReqBurst at acceptance.
REQ-014 In IDLE, Grant SHALL combinationally show the arbitration winner among asserted Req bits; zero if none.
REQ-015 Acceptance SHALL occur on a rising edge with HREADY=1 and Grant nonzero; it latches Owner, Threshold and clears BeatCount to 0, and the next state is BURST.
REQ-016 In IDLE without acceptance the state SHALL remain IDLE.
REQ-017 In BURST with BeatCount!=Threshold, Grant SHALL equal the Owner one-hot regardless of Req, and each HREADY edge increments BeatCount.
REQ-018 In BURST with BeatCount==Threshold, FinalBeat=1 and Grant SHALL show a fresh arbitration winner (address-phase handover).
REQ-019 At that final beat, on HREADY: if a winner exists, it is accepted per REQ-015 and the state stays BURST; otherwise the next state is IDLE.
REQ-020 Without HREADY, state, Owner, BeatCount and Threshold SHALL hold (wait states).
REQ-021 A requester dropping Req mid-burst SHALL NOT shorten the burst.
REQ-022 BeatCount SHALL be 4 bits and never exceed Threshold; there is no wrap.
REQ-023 Latency: grant is 0 cycles from Req in IDLE; a waiting requester is granted at the final beat of the current burst.

Reset
REQ-024 Asserting HRESET at any time, including mid-burst, SHALL force: state IDLE, BeatCount 0, Threshold 0, Owner 0, round-robin pointer 0, Busy 0, FinalBeat 0.
REQ-025 Grant during reset SHALL reflect IDLE arbitration of Req with pointer 0.

Configuration
REQ-026 Macro EBU_ARB_ROUNDROBIN_EN defined: the winner is the first asserted Req at or after the pointer, cyclically; the pointer becomes (accepted index+1) mod NREQ on each acceptance.
REQ-027 Macro undefined: fixed priority, lowest asserted index wins; the pointer is absent.

Structure
REQ-028 Package ebu_arb_pkg SHALL hold the state enum (IDLE, BURST) and a threshold function of HBURST.
REQ-029 Sub-module ebu_beatcnt (4-bit counter with clear, enable and a terminal-compare output) SHALL implement BeatCount/FinalBeat.

Verification
REQ-030 NREQ=3, Req=011, HBURST all 000, HREADY=1 -> with RR, grants go 0,1,0,1 on consecutive cycles; without RR, 0 every cycle.
REQ-031 Req0 with INCR4 (011) accepted, then Req1 raised -> Grant=001 for 3 cycles, FinalBeat on the 4th, Grant=010 on the 4th, owner 1 from the 5th.
REQ-032 INCR8 burst with HREADY low for 2 cycles at beat 3 -> BeatCount holds at 3; the burst ends after 8 HREADY beats.
REQ-033 HRESET pulsed at beat 5 of INCR16 -> the next cycle shows IDLE, Busy=0, BeatCount=0, pointer=0.
REQ-034 Final beat with Req=000 -> IDLE next cycle, Grant=000, GrantIdx=0.
REQ-035 Req0 drops during INCR4 -> Grant stays 001 until the final beat; 4 beats are counted.
